// File: rtl/dvfs_sequencer.sv
// DVFS actuation sequencer: applies freq/volt requests in a voltage-safe order
// (raise voltage, change frequency, lower voltage). Optional macro DVFS_SEQ_PGOOD_EN gates VUP on vreg_pgood.
module dvfs_sequencer #(
    parameter int unsigned VOLT_SETTLE_CYC = 16,
    parameter int unsigned FREQ_LOCK_CYC   = 8,
    parameter int unsigned TMR_W           = 8
`ifdef DVFS_SEQ_PGOOD_EN
    ,
    parameter int unsigned PGOOD_TMO_CYC   = 64
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] freq_req,
    input  logic [1:0] volt_req,
`ifdef DVFS_SEQ_PGOOD_EN
    input  logic       vreg_pgood,
`endif
    output logic [1:0] vreg_sel,
    output logic [1:0] clk_sel,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_VUP  = 2'd1,
        S_FCHG = 2'd2,
        S_VDN  = 2'd3
    } state_t;

    localparam logic [TMR_W-1:0] VOLT_LOAD = TMR_W'(VOLT_SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] FREQ_LOAD = TMR_W'(FREQ_LOCK_CYC - 1);

    state_t           state_q, state_d;
    logic [1:0]       vreg_sel_q, vreg_sel_d;
    logic [1:0]       clk_sel_q, clk_sel_d;
    logic [1:0]       tgt_f_q, tgt_f_d;
    logic [1:0]       tgt_v_q, tgt_v_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             launch_q, launch_d;

    logic req_illegal_s, req_new_s;
    logic need_vup_s, need_fchg_s, need_vdn_s;
    logic timer_zero_s, vup_exit_s, pg_tmo_s;

    assign req_illegal_s = (freq_req == 2'b11) || (volt_req == 2'b11);
    assign req_new_s     = {freq_req, volt_req} != {clk_sel_q, vreg_sel_q};
    assign need_vup_s    = tgt_v_q > vreg_sel_q;
    assign need_fchg_s   = tgt_f_q != clk_sel_q;
    assign need_vdn_s    = tgt_v_q < vreg_sel_q;
    assign timer_zero_s  = (timer_q == {TMR_W{1'b0}});

`ifdef DVFS_SEQ_PGOOD_EN
    localparam int unsigned      PG_W    = $clog2(PGOOD_TMO_CYC + 1);
    localparam logic [PG_W-1:0]  PG_LAST = PG_W'(PGOOD_TMO_CYC - 1);

    logic [PG_W-1:0] pg_cnt_q, pg_cnt_d;
    logic [1:0]      orig_v_q, orig_v_d;

    assign vup_exit_s = timer_zero_s && vreg_pgood;
    assign pg_tmo_s   = (state_q == S_VUP) && (pg_cnt_q == PG_LAST) && !vup_exit_s;
`else
    assign vup_exit_s = timer_zero_s;
    assign pg_tmo_s   = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            vreg_sel_q <= 2'b00;
            clk_sel_q  <= 2'b00;
            tgt_f_q    <= 2'b00;
            tgt_v_q    <= 2'b00;
            timer_q    <= {TMR_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            launch_q   <= 1'b0;
`ifdef DVFS_SEQ_PGOOD_EN
            pg_cnt_q   <= {PG_W{1'b0}};
            orig_v_q   <= 2'b00;
`endif
        end else begin
            state_q    <= state_d;
            vreg_sel_q <= vreg_sel_d;
            clk_sel_q  <= clk_sel_d;
            tgt_f_q    <= tgt_f_d;
            tgt_v_q    <= tgt_v_d;
            timer_q    <= timer_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            launch_q   <= launch_d;
`ifdef DVFS_SEQ_PGOOD_EN
            pg_cnt_q   <= pg_cnt_d;
            orig_v_q   <= orig_v_d;
`endif
        end
    end

    // Next-state: the first needed stage in VUP -> FCHG -> VDN order
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (launch_q) begin
                    if (need_vup_s) begin
                        state_d = S_VUP;
                    end else if (need_fchg_s) begin
                        state_d = S_FCHG;
                    end else if (need_vdn_s) begin
                        state_d = S_VDN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_VUP: begin
                if (pg_tmo_s) begin
                    state_d = S_IDLE;
                end else if (vup_exit_s) begin
                    state_d = need_fchg_s ? S_FCHG : S_IDLE;
                end else begin
                    state_d = S_VUP;
                end
            end
            S_FCHG: begin
                if (timer_zero_s) begin
                    state_d = need_vdn_s ? S_VDN : S_IDLE;
                end else begin
                    state_d = S_FCHG;
                end
            end
            S_VDN: begin
                state_d = timer_zero_s ? S_IDLE : S_VDN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register updates: request capture in IDLE, output/timer load on stage entry
    always_comb begin
        vreg_sel_d = vreg_sel_q;
        clk_sel_d  = clk_sel_q;
        tgt_f_d    = tgt_f_q;
        tgt_v_d    = tgt_v_q;
        timer_d    = timer_zero_s ? timer_q : timer_q - 1'b1;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        launch_d   = 1'b0;
`ifdef DVFS_SEQ_PGOOD_EN
        pg_cnt_d   = pg_cnt_q + 1'b1;
        orig_v_d   = orig_v_q;
`endif
        if ((state_q == S_IDLE) && !launch_q) begin
            if (req_illegal_s) begin
                err_d = 1'b1;
            end else if (req_new_s) begin
                tgt_f_d  = freq_req;
                tgt_v_d  = volt_req;
                launch_d = 1'b1;
`ifdef DVFS_SEQ_PGOOD_EN
                orig_v_d = vreg_sel_q;
`endif
            end else begin
                launch_d = 1'b0;
            end
        end else if (state_d != state_q) begin
            case (state_d)
                S_VUP: begin
                    vreg_sel_d = tgt_v_q;
                    timer_d    = VOLT_LOAD;
                    busy_d     = 1'b1;
`ifdef DVFS_SEQ_PGOOD_EN
                    pg_cnt_d   = {PG_W{1'b0}};
`endif
                end
                S_FCHG: begin
                    clk_sel_d = tgt_f_q;
                    timer_d   = FREQ_LOAD;
                    busy_d    = 1'b1;
                end
                S_VDN: begin
                    vreg_sel_d = tgt_v_q;
                    timer_d    = VOLT_LOAD;
                    busy_d     = 1'b1;
                end
                S_IDLE: begin
                    busy_d = 1'b0;
                    if (pg_tmo_s) begin
                        err_d = 1'b1;
`ifdef DVFS_SEQ_PGOOD_EN
                        vreg_sel_d = orig_v_q;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
                default: begin
                    busy_d = busy_q;
                end
            endcase
        end else begin
            busy_d = busy_q;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        vreg_sel = vreg_sel_q;
        clk_sel  = clk_sel_q;
        busy     = busy_q;
        done     = done_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_dvfs_sequencer.sv
// Scoreboard bench for dvfs_sequencer: expected output events are queued at stimulus
// time and matched in order against events captured from the DUT.
module tb_dvfs_sequencer;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  v;
        logic [1:0]  f;
        logic        d;
        logic        e;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] freq_req, volt_req;
    logic [1:0] vreg_sel, clk_sel;
    logic       busy, done, err;
`ifdef DVFS_SEQ_PGOOD_EN
    logic       vreg_pgood;
`endif

    int   cyc = 0;
    int   tests_run = 0;
    int   fails = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    logic [1:0] prev_v = 2'b00, prev_f = 2'b00;

    dvfs_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .freq_req (freq_req),
        .volt_req (volt_req),
`ifdef DVFS_SEQ_PGOOD_EN
        .vreg_pgood (vreg_pgood),
`endif
        .vreg_sel (vreg_sel),
        .clk_sel  (clk_sel),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output change and every done/err pulse as an event
    always @(negedge clk) begin
        if (reset_n && (vreg_sel != prev_v || clk_sel != prev_f || done || err))
            obs_q.push_back(ev_t'{32'(cyc), vreg_sel, clk_sel, done, err});
        prev_v <= vreg_sel;
        prev_f <= clk_sel;
    end

    task automatic test_reset();
        reset_n  = 1'b0;
        freq_req = 2'b10;
        volt_req = 2'b10;
`ifdef DVFS_SEQ_PGOOD_EN
        vreg_pgood = 1'b1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        tests_run++;
        if ({vreg_sel, clk_sel, busy, done, err} !== 7'b0) begin
            fails++;
            $display("FAIL reset_state: got v=%b f=%b busy=%b done=%b err=%b, want all zero",
                     vreg_sel, clk_sel, busy, done, err);
        end
    endtask

    task automatic test_raise();
        int a, bad;
        ev_t e, o;
        bad = 0;
        reset_n = 1'b1;
        a = cyc + 1;
        exp_q.push_back(ev_t'{32'(a + 1),  2'b10, 2'b00, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{32'(a + 17), 2'b10, 2'b10, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{32'(a + 25), 2'b10, 2'b10, 1'b1, 1'b0});
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk); #1;
            if (busy !== ((cyc >= a + 1) && (cyc <= a + 24))) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL raise_busy: got %0d wrong busy cycles, want 0", bad);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL raise_ev: got cyc=%0d v=%b f=%b d=%b e=%b, want cyc=%0d v=%b f=%b d=%b e=%b",
                         o.cyc, o.v, o.f, o.d, o.e, e.cyc, e.v, e.f, e.d, e.e);
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL raise_extra: got %0d extra events, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_lower();
        int a, bad;
        ev_t e, o;
        bad = 0;
        freq_req = 2'b00;
        volt_req = 2'b00;
        a = cyc + 1;
        exp_q.push_back(ev_t'{32'(a + 1),  2'b10, 2'b00, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{32'(a + 9),  2'b00, 2'b00, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{32'(a + 25), 2'b00, 2'b00, 1'b1, 1'b0});
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk); #1;
            if (clk_sel > vreg_sel) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL lower_safe: got %0d cycles with clk_sel>vreg_sel, want 0", bad);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL lower_ev: got cyc=%0d v=%b f=%b d=%b e=%b, want cyc=%0d v=%b f=%b d=%b e=%b",
                         o.cyc, o.v, o.f, o.d, o.e, e.cyc, e.v, e.f, e.d, e.e);
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL lower_extra: got %0d extra events, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    // 00/00 -> 01/01, then freq-only 00/01 with a mid-sequence request change that
    // must wait for done and then be accepted back-to-back
    task automatic test_back_to_back();
        int a, a2;
        ev_t e, o;
        freq_req = 2'b01;
        volt_req = 2'b01;
        a = cyc + 1;
        exp_q.push_back(ev_t'{32'(a + 1),  2'b01, 2'b00, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{32'(a + 17), 2'b01, 2'b01, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{32'(a + 25), 2'b01, 2'b01, 1'b1, 1'b0});
        repeat (27) begin @(negedge clk); #1; end
        freq_req = 2'b00;
        a  = cyc + 1;
        a2 = a + 10;
        exp_q.push_back(ev_t'{32'(a + 1),   2'b01, 2'b00, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{32'(a + 9),   2'b01, 2'b00, 1'b1, 1'b0});
        exp_q.push_back(ev_t'{32'(a2 + 1),  2'b10, 2'b00, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{32'(a2 + 17), 2'b10, 2'b10, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{32'(a2 + 25), 2'b10, 2'b10, 1'b1, 1'b0});
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk); #1;
            if (cyc == a + 4) begin
                freq_req = 2'b10;
                volt_req = 2'b10;
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL b2b_ev: got cyc=%0d v=%b f=%b d=%b e=%b, want cyc=%0d v=%b f=%b d=%b e=%b",
                         o.cyc, o.v, o.f, o.d, o.e, e.cyc, e.v, e.f, e.d, e.e);
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_extra: got %0d extra events, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_illegal();
        int a;
        ev_t e, o;
        freq_req = 2'b11;
        a = cyc + 1;
        exp_q.push_back(ev_t'{32'(a),     2'b10, 2'b10, 1'b0, 1'b1});
        exp_q.push_back(ev_t'{32'(a + 2), 2'b10, 2'b10, 1'b0, 1'b1});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); #1;
            if (cyc == a)     freq_req = 2'b10;
            if (cyc == a + 1) volt_req = 2'b11;
            if (cyc == a + 2) volt_req = 2'b10;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL illegal_ev: got cyc=%0d v=%b f=%b d=%b e=%b, want cyc=%0d v=%b f=%b d=%b e=%b",
                         o.cyc, o.v, o.f, o.d, o.e, e.cyc, e.v, e.f, e.d, e.e);
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL illegal_extra: got %0d extra events, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int a;
        ev_t e, o;
        freq_req = 2'b00;
        volt_req = 2'b00;
        a = cyc + 1;
        exp_q.push_back(ev_t'{32'(a + 1), 2'b10, 2'b00, 1'b0, 1'b0});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); #1;
            if (cyc == a + 4) reset_n = 1'b0;
            if (cyc == a + 5) begin
                tests_run++;
                if ({vreg_sel, clk_sel, busy, done, err} !== 7'b0) begin
                    fails++;
                    $display("FAIL reset_mid: got v=%b f=%b busy=%b done=%b err=%b, want all zero",
                             vreg_sel, clk_sel, busy, done, err);
                end
                reset_n = 1'b1;
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_busy: got %b, want 0", busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset_mid_ev: got cyc=%0d v=%b f=%b d=%b e=%b, want cyc=%0d v=%b f=%b d=%b e=%b",
                         o.cyc, o.v, o.f, o.d, o.e, e.cyc, e.v, e.f, e.d, e.e);
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL reset_mid_extra: got %0d extra events, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

`ifdef DVFS_SEQ_PGOOD_EN
    // pgood stuck low times out and restores voltage; the pending request is
    // retried and completes once pgood rises on cycle 20 of the retry
    task automatic test_pgood();
        int a, a2;
        ev_t e, o;
        vreg_pgood = 1'b0;
        freq_req   = 2'b10;
        volt_req   = 2'b10;
        a  = cyc + 1;
        a2 = a + 66;
        exp_q.push_back(ev_t'{32'(a + 1),   2'b10, 2'b00, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{32'(a + 65),  2'b00, 2'b00, 1'b0, 1'b1});
        exp_q.push_back(ev_t'{32'(a2 + 1),  2'b10, 2'b00, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{32'(a2 + 21), 2'b10, 2'b10, 1'b0, 1'b0});
        exp_q.push_back(ev_t'{32'(a2 + 29), 2'b10, 2'b10, 1'b1, 1'b0});
        for (int k = 1; k <= 66 + 31; k++) begin
            @(negedge clk); #1;
            if (cyc == a2 + 20) vreg_pgood = 1'b1;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
            tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL pgood_ev: got cyc=%0d v=%b f=%b d=%b e=%b, want cyc=%0d v=%b f=%b d=%b e=%b",
                         o.cyc, o.v, o.f, o.d, o.e, e.cyc, e.v, e.f, e.d, e.e);
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL pgood_extra: got %0d extra events, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_raise();
        test_lower();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
`ifdef DVFS_SEQ_PGOOD_EN
        test_pgood();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
